// File: rtl/lsu_pkg.sv
// Shared types and helpers for the AXI4-Lite load/store unit.
package lsu_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    MR_B  = 3'd0,
    MR_H  = 3'd1,
    MR_W  = 3'd2,
    MR_BU = 3'd3,
    MR_HU = 3'd4
  } mrtype_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  // Request fields still needed after the address phase has been issued
  typedef struct packed {
    logic [1:0] offset;
    logic [2:0] mrtype;
  } lsu_req_t;

  // Stores are sized by their byte mask, loads by mrtype
  function automatic logic misaligned(input logic isStore, input logic [1:0] offset,
                                      input logic [3:0] wmask, input logic [2:0] rtype);
    logic isHalf;
    logic isWord;
    if (isStore) begin
      isHalf = (wmask == 4'b0011);
      isWord = (wmask == 4'b1111);
    end else begin
      isHalf = (rtype == MR_H) || (rtype == MR_HU);
      isWord = (rtype == MR_W);
    end
    return (isHalf && offset[0]) || (isWord && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: shifts the read word down by the byte
// offset and sign/zero-extends it according to mrtype.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mrtype,
  output logic [31:0] mdata_c
);

  logic [31:0] sh;

  always_comb begin
    sh      = rdata >> {offset, 3'b000};
    mdata_c = '0;
    case (mrtype)
      MR_B:    mdata_c = {{24{sh[7]}}, sh[7:0]};
      MR_H:    mdata_c = {{16{sh[15]}}, sh[15:0]};
      MR_W:    mdata_c = sh;
      MR_BU:   mdata_c = {24'h0, sh[7:0]};
      MR_HU:   mdata_c = {16'h0, sh[15:0]};
      default: mdata_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_axi.sv
// Memory-stage load/store unit with an AXI4-Lite master port.
// Optional LSU_MISALIGN_CHK_EN: misaligned half/word accesses fail locally with m_err.
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // upstream (M stage)
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  mvalid,
  input  logic                  mwen,
  input  logic [ADDR_W-1:0]     maddr,
  input  logic [DATA_W-1:0]     mwdata,
  input  logic [DATA_W/8-1:0]   mwmask,
  input  logic [2:0]            mrtype,
  // downstream (W stage)
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     mdata,
  output logic                  m_err,
  // AXI4-Lite read
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI4-Lite write
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  lsu_state_e          state, stateNext;
  lsu_req_t            reqQ, reqNext;
  logic                sReadyNext, mValidNext, mErrNext;
  logic [DATA_W-1:0]   mdataNext, wdataNext, loadData;
  logic [ADDR_W-1:0]   araddrNext, awaddrNext, alignedAddr;
  logic [STRB_W-1:0]   wstrbNext;
  logic                arvalidNext, rreadyNext, awvalidNext, wvalidNext, breadyNext;
  logic                awDone, wDone, misalignErr;

  assign alignedAddr = {maddr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHK_EN
  assign misalignErr = mvalid && misaligned(mwen, maddr[1:0], mwmask, mrtype);
`else
  assign misalignErr = 1'b0;
`endif

  lsu_load_align uLoadAlign (
    .rdata   (rdata),
    .offset  (reqQ.offset),
    .mrtype  (reqQ.mrtype),
    .mdata_c (loadData)
  );

  // An AW/W channel counts as done once its valid has already dropped or is handshaking now
  assign awDone = !awvalid || awready;
  assign wDone  = !wvalid  || wready;

  // Next-state and next-output logic
  always_comb begin
    stateNext   = state;
    reqNext     = reqQ;
    mValidNext  = m_valid;
    mErrNext    = m_err;
    mdataNext   = mdata;
    araddrNext  = araddr;
    arvalidNext = arvalid;
    rreadyNext  = rready;
    awaddrNext  = awaddr;
    awvalidNext = awvalid;
    wdataNext   = wdata;
    wstrbNext   = wstrb;
    wvalidNext  = wvalid;
    breadyNext  = bready;

    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          reqNext   = '{offset: maddr[1:0], mrtype: mrtype};
          mErrNext  = 1'b0;
          mdataNext = '0;
          if (!mvalid || misalignErr) begin
            stateNext  = DONE;
            mValidNext = 1'b1;
            mErrNext   = misalignErr;
          end else if (mwen) begin
            stateNext   = WR_AW;
            awaddrNext  = alignedAddr;
            wdataNext   = mwdata << {maddr[1:0], 3'b000};
            wstrbNext   = mwmask << maddr[1:0];
            awvalidNext = 1'b1;
            wvalidNext  = 1'b1;
          end else begin
            stateNext   = RD_A;
            araddrNext  = alignedAddr;
            arvalidNext = 1'b1;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          stateNext   = RD_D;
          arvalidNext = 1'b0;
          rreadyNext  = 1'b1;
        end
      end
      RD_D: begin
        if (rvalid) begin
          stateNext  = DONE;
          rreadyNext = 1'b0;
          mValidNext = 1'b1;
          mErrNext   = (rresp != AXI_RESP_OKAY);
          mdataNext  = (rresp != AXI_RESP_OKAY) ? '0 : loadData;
        end
      end
      WR_AW: begin
        if (awvalid && awready) awvalidNext = 1'b0;
        if (wvalid && wready)   wvalidNext  = 1'b0;
        if (awDone && wDone) begin
          stateNext  = WR_B;
          breadyNext = 1'b1;
        end
      end
      WR_B: begin
        if (bvalid) begin
          stateNext  = DONE;
          breadyNext = 1'b0;
          mValidNext = 1'b1;
          mErrNext   = (bresp != AXI_RESP_OKAY);
          mdataNext  = '0;
        end
      end
      DONE: begin
        if (m_ready) begin
          stateNext  = IDLE;
          mValidNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase

    sReadyNext = (stateNext == IDLE);
  end

  // State and output registers; reset drops every valid immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      reqQ    <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      mdata   <= '0;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      state   <= stateNext;
      reqQ    <= reqNext;
      s_ready <= sReadyNext;
      m_valid <= mValidNext;
      m_err   <= mErrNext;
      mdata   <= mdataNext;
      araddr  <= araddrNext;
      arvalid <= arvalidNext;
      rready  <= rreadyNext;
      awaddr  <= awaddrNext;
      awvalid <= awvalidNext;
      wdata   <= wdataNext;
      wstrb   <= wstrbNext;
      wvalid  <= wvalidNext;
      bready  <= breadyNext;
    end
  end

endmodule

// File: tb/tb_lsu_axi.sv
// Directed self-checking bench for lsu_axi with a delay-configurable AXI4-Lite slave.
module tb_lsu_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid, s_ready, mvalid, mwen;
  logic [31:0] maddr, mwdata;
  logic [3:0]  mwmask;
  logic [2:0]  mrtype;
  logic        m_valid, m_ready, m_err;
  logic [31:0] mdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  lsu_axi dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .mvalid(mvalid), .mwen(mwen),
    .maddr(maddr), .mwdata(mwdata), .mwmask(mwmask), .mrtype(mrtype),
    .m_valid(m_valid), .m_ready(m_ready), .mdata(mdata), .m_err(m_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Slave model: ready after N cycles of valid, response N cycles after address/data
  int          arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
  logic [1:0]  rrespCfg = 2'b00, brespCfg = 2'b00;
  logic [31:0] mem [0:15];
  int          arWait, rCnt, awWait, wWait, bCnt;
  int          arHs, bHs;
  logic        rPending, bPending, awGot, wGot;
  logic [3:0]  rIdx, awIdx, wrIdx;
  logic [31:0] lastAwaddr, lastWdata, wrData;
  logic [3:0]  lastWstrb, wrStrb;
  logic        awHs, wHs;

  assign arready = arvalid && (arWait >= arDelay);
  assign awready = awvalid && (awWait >= awDelay);
  assign wready  = wvalid  && (wWait  >= wDelay);
  assign rvalid  = rPending && (rCnt == 0);
  assign bvalid  = bPending && (bCnt == 0);
  assign rdata   = mem[rIdx];
  assign rresp   = rrespCfg;
  assign bresp   = brespCfg;
  assign awHs    = awvalid && awready;
  assign wHs     = wvalid && wready;
  assign wrIdx   = awHs ? awaddr[5:2] : awIdx;
  assign wrData  = wHs ? wdata : lastWdata;
  assign wrStrb  = wHs ? wstrb : lastWstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arWait <= 0; rCnt <= 0; awWait <= 0; wWait <= 0; bCnt <= 0;
      arHs <= 0; bHs <= 0;
      rPending <= 1'b0; bPending <= 1'b0; awGot <= 1'b0; wGot <= 1'b0;
      rIdx <= '0; awIdx <= '0;
      lastAwaddr <= '0; lastWdata <= '0; lastWstrb <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (arvalid && !arready) arWait <= arWait + 1;
      if (arvalid && arready) begin
        arWait <= 0; rIdx <= araddr[5:2]; rPending <= 1'b1; rCnt <= rDelay; arHs <= arHs + 1;
      end else if (rPending && rCnt != 0) rCnt <= rCnt - 1;
      if (rvalid && rready) rPending <= 1'b0;

      if (awvalid && !awready) awWait <= awWait + 1;
      if (awHs) begin awWait <= 0; awIdx <= awaddr[5:2]; lastAwaddr <= awaddr; awGot <= 1'b1; end
      if (wvalid && !wready) wWait <= wWait + 1;
      if (wHs) begin wWait <= 0; lastWdata <= wdata; lastWstrb <= wstrb; wGot <= 1'b1; end
      if ((awGot || awHs) && (wGot || wHs)) begin
        for (int b = 0; b < 4; b++)
          if (wrStrb[b]) mem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
        awGot <= 1'b0; wGot <= 1'b0; bPending <= 1'b1; bCnt <= bDelay;
      end else if (bPending && bCnt != 0) bCnt <= bCnt - 1;
      if (bvalid && bready) begin bPending <= 1'b0; bHs <= bHs + 1; end
    end
  end

  // Protocol monitor: valid held until ready, payload stable, B only after AW+W
  int          axiViol = 0, busyViol = 0, wHeldCnt = 0;
  logic        busy = 1'b0;
  logic        pArv = 1'b0, pArr, pAwv = 1'b0, pAwr, pWv = 1'b0, pWr;
  logic [31:0] pAraddr, pAwaddr, pWdata;
  logic [3:0]  pWstrb;

  always @(negedge clk) begin
    if (!rst_n) begin
      pArv <= 1'b0; pAwv <= 1'b0; pWv <= 1'b0;
    end else begin
      if (pArv && !pArr && (!arvalid || araddr != pAraddr)) axiViol <= axiViol + 1;
      if (pAwv && !pAwr && (!awvalid || awaddr != pAwaddr)) axiViol <= axiViol + 1;
      if (pWv && !pWr && (!wvalid || wdata != pWdata || wstrb != pWstrb)) axiViol <= axiViol + 1;
      if (bready && (awvalid || wvalid)) axiViol <= axiViol + 1;
      if (busy && s_ready) busyViol <= busyViol + 1;
      if (!awvalid && wvalid) wHeldCnt <= wHeldCnt + 1;
      pArv <= arvalid; pArr <= arready; pAraddr <= araddr;
      pAwv <= awvalid; pAwr <= awready; pAwaddr <= awaddr;
      pWv <= wvalid; pWr <= wready; pWdata <= wdata; pWstrb <= wstrb;
    end
  end

  int nAsserts = 0, nFails = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic startOp(input string tag, input logic mv, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] mk, input logic [2:0] rt);
    @(negedge clk);
    checkVal({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    s_valid = 1'b1; mvalid = mv; mwen = mw; maddr = a; mwdata = d; mwmask = mk; mrtype = rt;
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    // Upstream is free to change once accepted
    s_valid = 1'b0; mvalid = 1'b0; mwen = 1'(~mw);
    maddr = $urandom; mwdata = $urandom; mwmask = 4'($urandom); mrtype = 3'($urandom);
  endtask

  task automatic waitDone(input string tag, output int lat);
    lat = 1;
    while (!m_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!m_valid) checkVal({tag, "_timeout"}, 32'(m_valid), 32'd1);
  endtask

  task automatic finishOp();
    m_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic mv, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] mk, input logic [2:0] rt,
                       input int expLat, input logic [31:0] expData, input logic expErr);
    int lat;
    startOp(tag, mv, mw, a, d, mk, rt);
    waitDone(tag, lat);
    checkVal({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkVal({tag, "_mdata"}, mdata, expData);
    checkVal({tag, "_m_err"}, 32'(m_err), 32'(expErr));
    finishOp();
  endtask

  int lat, a0, b0, h0;

  initial begin
    s_valid = 0; mvalid = 0; mwen = 0; maddr = 0; mwdata = 0; mwmask = 0; mrtype = 0; m_ready = 0;
    repeat (2) @(negedge clk);
    checkVal("rst_s_ready", 32'(s_ready), 32'd1);
    checkVal("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready, m_valid, m_err}), 32'd0);
    checkVal("rst_mdata", mdata, 32'd0);
    rst_n = 1'b1;

    // sw / sb and their read-back with sign and zero extension
    runOp("sw", 1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 3'd2, 3, 32'h0, 1'b0);
    checkVal("sw_awaddr", lastAwaddr, 32'h8000_0004);
    checkVal("sw_wstrb", 32'(lastWstrb), 32'hF);
    checkVal("sw_wdata", lastWdata, 32'hDEAD_BEEF);
    runOp("sb", 1, 1, 32'h8000_0003, 32'h0000_00AB, 4'b0001, 3'd0, 3, 32'h0, 1'b0);
    checkVal("sb_awaddr", lastAwaddr, 32'h8000_0000);
    checkVal("sb_wdata", lastWdata, 32'hAB00_0000);
    checkVal("sb_wstrb", 32'(lastWstrb), 32'h8);
    runOp("lb", 1, 0, 32'h8000_0003, 32'h0, 4'h0, 3'd0, 3, 32'hFFFF_FFAB, 1'b0);
    runOp("lbu", 1, 0, 32'h8000_0003, 32'h0, 4'h0, 3'd3, 3, 32'h0000_00AB, 1'b0);
    runOp("lh", 1, 0, 32'h8000_0006, 32'h0, 4'h0, 3'd1, 3, 32'hFFFF_DEAD, 1'b0);
    runOp("lhu", 1, 0, 32'h8000_0006, 32'h0, 4'h0, 3'd4, 3, 32'h0000_DEAD, 1'b0);
    runOp("lw", 1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'd2, 3, 32'hDEAD_BEEF, 1'b0);
    runOp("rtype5", 1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'd5, 3, 32'h0, 1'b0);
    runOp("pass", 0, 1, 32'h8000_0004, 32'h1234_5678, 4'hF, 3'd2, 1, 32'h0, 1'b0);

    // AW accepted two cycles before W
    wDelay = 2; b0 = bHs; h0 = wHeldCnt;
    runOp("sh_wlate", 1, 1, 32'h8000_0008, 32'h0000_1234, 4'b0011, 3'd1, 5, 32'h0, 1'b0);
    checkVal("sh_wlate_bcount", 32'(bHs - b0), 32'd1);
    checkVal("sh_wlate_aw_first", 32'(wHeldCnt > h0), 32'd1);
    checkVal("sh_wlate_wdata", lastWdata, 32'h0000_1234);
    wDelay = 0;
    runOp("sh_hi", 1, 1, 32'h8000_000A, 32'h0000_5678, 4'b0011, 3'd1, 3, 32'h0, 1'b0);
    checkVal("sh_hi_wstrb", 32'(lastWstrb), 32'hC);
    runOp("lw_halves", 1, 0, 32'h8000_0008, 32'h0, 4'h0, 3'd2, 3, 32'h5678_1234, 1'b0);

    // Slow slave, W stage stalls for two cycles
    arDelay = 3; rDelay = 4;
    startOp("lw_slow", 1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'd2);
    waitDone("lw_slow", lat);
    checkVal("lw_slow_lat", 32'(lat), 32'd10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("lw_slow_hold_valid", 32'(m_valid), 32'd1);
      checkVal("lw_slow_hold_mdata", mdata, 32'hDEAD_BEEF);
    end
    finishOp();
    arDelay = 0; rDelay = 0;

    // Error responses
    rrespCfg = 2'b10;
    runOp("lw_slverr", 1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'd2, 3, 32'h0, 1'b1);
    rrespCfg = 2'b00; brespCfg = 2'b11;
    runOp("sw_decerr", 1, 1, 32'h8000_000C, 32'h0BAD_F00D, 4'hF, 3'd2, 3, 32'h0, 1'b1);
    brespCfg = 2'b00;

    a0 = arHs;
`ifdef LSU_MISALIGN_CHK_EN
    runOp("lh_misalign", 1, 0, 32'h8000_0001, 32'h0, 4'h0, 3'd1, 1, 32'h0, 1'b1);
    checkVal("lh_misalign_no_ar", 32'(arHs - a0), 32'd0);
`else
    runOp("lw_unaligned", 1, 0, 32'h8000_0005, 32'h0, 4'h0, 3'd2, 3, 32'h00DE_ADBE, 1'b0);
    checkVal("lw_unaligned_ar", 32'(arHs - a0), 32'd1);
`endif

    // Reset while waiting for read data
    rDelay = 10;
    startOp("rst_mid", 1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'd2);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    checkVal("rst_mid_in_rd_d", 32'(rready), 32'd1);
    #2 rst_n = 1'b0;
    busy = 1'b0;
    #1;
    checkVal("rst_mid_drop", 32'({arvalid, rready, m_valid, awvalid, wvalid, bready}), 32'd0);
    rDelay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    runOp("post_rst_pass", 0, 0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 32'h0, 1'b0);

    checkVal("axi_protocol", 32'(axiViol), 32'd0);
    checkVal("s_ready_while_busy", 32'(busyViol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
